multicycle_ctrl: RTL

Multi-cycle control FSM that sequences the shared-memory MIPS datapath through fetch, decode, execute, memory and writeback. It replaces the single-cycle combinational decoder and drives all datapath enables and mux selects each cycle. It stalls on a memory ready handshake. One unified memory port serves both instruction and data accesses.

---
 rtl/ctrl_pkg.sv | 87 ++++++++
 rtl/alu_op_decode.sv | 58 +++++
 rtl/multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU operation
// codes, instruction fields and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_RWB,
        S_EXEC_I,
        S_IWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_JR
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_ADDU = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_SUBU = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_SRL  = 4'hA;
    localparam logic [3:0] ALU_SRA  = 4'hB;
    localparam logic [3:0] ALU_JR   = 4'hC;
    localparam logic [3:0] ALU_BNE  = 4'hD;
    localparam logic [3:0] ALU_LUI  = 4'hE;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction classifier: maps opcode/shamt/func to an ALU
// operation and flags encodings the datapath does not support.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] shamt,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       legal
);

    logic shift_ok;
    assign shift_ok = (shamt != 5'd0);

    always_comb begin
        alu_op = ALU_NOP;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_ADDU: alu_op = ALU_ADDU;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SUBU: alu_op = ALU_SUBU;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR:   alu_op = ALU_JR;
                    // sll with a zero shift is the canonical nop, still legal
                    FN_SLL:  alu_op = shift_ok ? ALU_SLL : ALU_NOP;
                    FN_SRL: begin
                        alu_op = ALU_SRL;
                        legal  = shift_ok;
                    end
                    FN_SRA: begin
                        alu_op = ALU_SRA;
                        legal  = shift_ok;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI:       alu_op = ALU_ADD;
            OP_SUBI:       alu_op = ALU_SUB;
            OP_ANDI:       alu_op = ALU_AND;
            OP_ORI:        alu_op = ALU_OR;
            OP_SLTI:       alu_op = ALU_SLT;
            OP_LUI:        alu_op = ALU_LUI;
            OP_LW, OP_SW:  alu_op = ALU_ADD;
            OP_BEQ:        alu_op = ALU_SUB;
            OP_BNE:        alu_op = ALU_BNE;
            OP_J, OP_JAL:  alu_op = ALU_NOP;
            default:       legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared-memory MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int RA_IDX      = 31,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [4:0] shamt,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       IorD,
    output logic       IRWrite,
    output logic       pc_write,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [15:0] TO_LAST = (MEM_TIMEOUT > 0) ? 16'(MEM_TIMEOUT - 1) : 16'd0;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [3:0]  dec_alu_op;
    logic        dec_legal;
    logic        is_nop;
    logic        timeout_hit;

    // RA_IDX is applied by the register-file address mux; this block only selects it.
    logic unused_ra;
    assign unused_ra = ^5'(RA_IDX);

    alu_op_decode u_dec (
        .opcode (opcode),
        .shamt  (shamt),
        .func   (func),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    assign is_nop = (opcode == OP_RTYPE) && (func == FN_SLL) && (shamt == 5'd0);

    assign timeout_hit = (MEM_TIMEOUT > 0) && is_wait_state(state) && !mem_ready
                         && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 16'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_hit)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        pc_write   = 1'b0;
        PCSource   = PCS_ALU;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        ALUOp      = ALU_ADD;
        RegDst     = RD_RT;
        MemtoReg   = M2R_ALUOUT;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        // Reset silences every strobe at once, dropping any open access.
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH;
                    if (!dec_legal) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        case (opcode)
                            OP_RTYPE: begin
                                if (is_nop) begin
                                    instr_done = 1'b1;
                                    state_nxt  = S_FETCH;
                                end else if (func == FN_JR) begin
                                    state_nxt = S_JR;
                                end else begin
                                    state_nxt = S_EXEC_R;
                                end
                            end
                            OP_LW, OP_SW:   state_nxt = S_MEMADR;
                            OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                            OP_J, OP_JAL:   state_nxt = S_JUMP;
                            OP_ADDI, OP_SUBI, OP_ANDI,
                            OP_ORI, OP_SLTI, OP_LUI: state_nxt = S_EXEC_I;
                            default: begin
                                instr_done = 1'b1;
                                state_nxt  = S_FETCH;
                            end
                        endcase
                    end
                end
                S_EXEC_R: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_REGB;
                    ALUOp     = dec_alu_op;
                    state_nxt = S_RWB;
                end
                S_RWB: begin
                    RegDst     = RD_RD;
                    MemtoReg   = M2R_ALUOUT;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_EXEC_I: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_IMM;
                    ALUOp     = dec_alu_op;
                    state_nxt = S_IWB;
                end
                S_IWB: begin
                    RegDst     = RD_RT;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEMADR: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_IMM;
                    ALUOp     = ALU_ADD;
                    state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready)
                        state_nxt = S_MEMWB;
                end
                S_MEMWB: begin
                    RegDst     = RD_RT;
                    MemtoReg   = M2R_MDR;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    IorD      = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_REGB;
                    ALUOp      = ALU_SUB;
                    PCSource   = PCS_ALUOUT;
                    pc_write   = (opcode == OP_BNE) ? !zero : zero;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_JUMP: begin
                    PCSource   = PCS_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    // PC already holds PC+4 from fetch, which is the link value
                    if (opcode == OP_JAL) begin
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                        RegWrite = 1'b1;
                    end
                    state_nxt = S_FETCH;
                end
                S_JR: begin
                    ALUSrcA    = 1'b1;
                    PCSource   = PCS_REGA;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase

            // An expired wait abandons the access without committing anything.
            if (timeout_hit)
                state_nxt = S_FETCH;
        end
    end

    always_comb begin
        wait_cnt_nxt = 16'd0;
        if ((MEM_TIMEOUT > 0) && is_wait_state(state) && !mem_ready && !timeout_hit)
            wait_cnt_nxt = wait_cnt + 16'd1;
    end

endmodule
